// File: rtl/cmp_result_monitor.sv
// Monitors a registered comparator flag triple: saturating per-result and error totals,
// plus run tracking that pulses run_hit when RUN_LEN identical results arrive in a row.
module cmp_result_monitor #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned RUN_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             a_gt_b,
  input  logic             a_lt_b,
  input  logic             a_eq_b,
  input  logic             clr,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       run_state,
  output logic             run_hit,
  output logic [1:0]       run_type
);

  typedef enum logic [1:0] {
    StNone = 2'b00,
    StGt   = 2'b01,
    StLt   = 2'b10,
    StEq   = 2'b11
  } run_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       RunLen = 8'(RUN_LEN);

  run_e             state_q, state_d;
  logic [7:0]       rl_q, rl_d;
  logic [CNT_W-1:0] gt_q, gt_d;
  logic [CNT_W-1:0] lt_q, lt_d;
  logic [CNT_W-1:0] eq_q, eq_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             hit_q, hit_d;
  logic [1:0]       type_q, type_d;

  run_e sample_type;
  logic one_hot;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + CntOne;
  endfunction

  // Decode the flag triple; anything other than exactly one flag high is an error sample.
  always_comb begin
    sample_type = StNone;
    one_hot     = 1'b0;
    case ({a_gt_b, a_lt_b, a_eq_b})
      3'b100: begin
        sample_type = StGt;
        one_hot     = 1'b1;
      end
      3'b010: begin
        sample_type = StLt;
        one_hot     = 1'b1;
      end
      3'b001: begin
        sample_type = StEq;
        one_hot     = 1'b1;
      end
      default: begin
        sample_type = StNone;
        one_hot     = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    rl_d    = rl_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    err_d   = err_q;
    hit_d   = 1'b0;
    type_d  = type_q;

    if (clr) begin
      state_d = StNone;
      rl_d    = 8'd0;
      gt_d    = '0;
      lt_d    = '0;
      eq_d    = '0;
      err_d   = '0;
      type_d  = 2'b00;
    end else if (in_valid) begin
      if (!one_hot) begin
        err_d   = sat_inc(err_q);
        state_d = StNone;
        rl_d    = 8'd0;
      end else begin
        case (sample_type)
          StGt:    gt_d = sat_inc(gt_q);
          StLt:    lt_d = sat_inc(lt_q);
          StEq:    eq_d = sat_inc(eq_q);
          default: gt_d = gt_q;
        endcase
        if (state_q != sample_type) begin
          state_d = sample_type;
          rl_d    = 8'd1;
        end else if (rl_q < RunLen) begin
          // Only the RUN_LEN-1 -> RUN_LEN transition fires; a saturated run stays quiet.
          rl_d = rl_q + 8'd1;
          if (rl_q == RunLen - 8'd1) begin
            hit_d  = 1'b1;
            type_d = sample_type;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StNone;
      rl_q    <= 8'd0;
      gt_q    <= '0;
      lt_q    <= '0;
      eq_q    <= '0;
      err_q   <= '0;
      hit_q   <= 1'b0;
      type_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      rl_q    <= rl_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      err_q   <= err_d;
      hit_q   <= hit_d;
      type_q  <= type_d;
    end
  end

  assign gt_count  = gt_q;
  assign lt_count  = lt_q;
  assign eq_count  = eq_q;
  assign err_count = err_q;
  assign run_state = state_q;
  assign run_hit   = hit_q;
  assign run_type  = type_q;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Scoreboarded bench for cmp_result_monitor: a default-width and a CNT_W=4 instance share
// stimulus; a behavioural model queues expected outputs for every driven cycle.
module tb_cmp_result_monitor;

  localparam int RunLen = 4;

  // Stimulus code: {rst, clr, in_valid, a_gt_b, a_lt_b, a_eq_b}
  localparam logic [5:0] SIdle  = 6'b000000;
  localparam logic [5:0] SRst   = 6'b100000;
  localparam logic [5:0] SGt    = 6'b001100;
  localparam logic [5:0] SLt    = 6'b001010;
  localparam logic [5:0] SEq    = 6'b001001;
  localparam logic [5:0] SE000  = 6'b001000;
  localparam logic [5:0] SE110  = 6'b001110;
  localparam logic [5:0] SClrEq = 6'b011001;
  localparam logic [5:0] SRstEq = 6'b101001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic a_gt_b = 1'b0;
  logic a_lt_b = 1'b0;
  logic a_eq_b = 1'b0;

  logic [15:0] gt16, lt16, eq16, err16;
  logic [1:0]  rs16, rt16;
  logic        hit16;
  logic [3:0]  gt4, lt4, eq4, err4;
  logic [1:0]  rs4, rt4;
  logic        hit4;

  always #5 clk = ~clk;

  cmp_result_monitor #(.CNT_W(16), .RUN_LEN(RunLen)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a_gt_b(a_gt_b), .a_lt_b(a_lt_b),
    .a_eq_b(a_eq_b), .clr(clr), .gt_count(gt16), .lt_count(lt16), .eq_count(eq16),
    .err_count(err16), .run_state(rs16), .run_hit(hit16), .run_type(rt16)
  );

  cmp_result_monitor #(.CNT_W(4), .RUN_LEN(RunLen)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a_gt_b(a_gt_b), .a_lt_b(a_lt_b),
    .a_eq_b(a_eq_b), .clr(clr), .gt_count(gt4), .lt_count(lt4), .eq_count(eq4),
    .err_count(err4), .run_state(rs4), .run_hit(hit4), .run_type(rt4)
  );

  wire [89:0] obs = {gt16, lt16, eq16, err16, rs16, hit16, rt16,
                     gt4, lt4, eq4, err4, rs4, hit4, rt4};

  int n_cmp = 0;
  int n_bad = 0;
  logic [89:0] sb[$];
  logic [5:0]  stim[$];
  logic [89:0] e;

  // Behavioural model state; counts kept unbounded and clipped per width when packed.
  int m_gt, m_lt, m_eq, m_err, m_state, m_rl, m_type;
  logic m_hit;

  function automatic int clip(input int x, input int mx);
    return (x > mx) ? mx : x;
  endfunction

  function automatic logic [89:0] model_pack();
    logic [15:0] g16, l16, q16, r16;
    logic [3:0]  g4, l4, q4, r4;
    g16 = 16'(clip(m_gt, 65535));
    l16 = 16'(clip(m_lt, 65535));
    q16 = 16'(clip(m_eq, 65535));
    r16 = 16'(clip(m_err, 65535));
    g4  = 4'(clip(m_gt, 15));
    l4  = 4'(clip(m_lt, 15));
    q4  = 4'(clip(m_eq, 15));
    r4  = 4'(clip(m_err, 15));
    return {g16, l16, q16, r16, 2'(m_state), m_hit, 2'(m_type),
            g4, l4, q4, r4, 2'(m_state), m_hit, 2'(m_type)};
  endfunction

  task automatic step(input logic [5:0] s);
    int t;
    {rst, clr, in_valid, a_gt_b, a_lt_b, a_eq_b} = s;
    m_hit = 1'b0;
    if (s[5] || s[4]) begin
      m_gt = 0; m_lt = 0; m_eq = 0; m_err = 0;
      m_state = 0; m_rl = 0; m_type = 0;
    end else if (s[3]) begin
      case (s[2:0])
        3'b100:  t = 1;
        3'b010:  t = 2;
        3'b001:  t = 3;
        default: t = 0;
      endcase
      if (t == 0) begin
        m_err++;
        m_state = 0;
        m_rl = 0;
      end else begin
        if (t == 1) m_gt++;
        if (t == 2) m_lt++;
        if (t == 3) m_eq++;
        if (m_state != t) begin
          m_state = t;
          m_rl = 1;
        end else if (m_rl < RunLen) begin
          m_rl++;
          if (m_rl == RunLen) begin
            m_hit = 1'b1;
            m_type = t;
          end
        end
      end
    end
    sb.push_back(model_pack());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim = '{SRst, SIdle};
    foreach (stim[i]) begin
      step(stim[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL reset[%0d]: got %h want %h", i, obs, e);
      end
    end
    n_cmp++;
    if ($isunknown(obs) || obs !== 90'd0) begin
      n_bad++;
      $display("FAIL reset_no_x: got %h want all zero", obs);
    end
  endtask

  task automatic test_eq_run();
    stim = '{SRst, SEq, SEq, SEq, SEq, SIdle};
    foreach (stim[i]) begin
      step(stim[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL eq_run[%0d]: got %h want %h", i, obs, e);
      end
      if (i == 4) begin
        n_cmp++;
        if (eq16 !== 16'd4 || rs16 !== 2'b11 || hit16 !== 1'b1 || rt16 !== 2'b11) begin
          n_bad++;
          $display("FAIL eq_run_hit: eq=%0d st=%b hit=%b type=%b want 4/11/1/11",
                   eq16, rs16, hit16, rt16);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if (hit16 !== 1'b0 || rt16 !== 2'b11) begin
          n_bad++;
          $display("FAIL eq_run_pulse: hit=%b type=%b want 0/11", hit16, rt16);
        end
      end
    end
  endtask

  task automatic test_break();
    stim = '{SRst, SGt, SGt, SGt, SLt, SGt, SGt, SGt, SGt};
    foreach (stim[i]) begin
      step(stim[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL break[%0d]: got %h want %h", i, obs, e);
      end
      if (i == 3 || i == 4) begin
        n_cmp++;
        if (hit16 !== 1'b0 || (i == 4 && rs16 !== 2'b10)) begin
          n_bad++;
          $display("FAIL break_early[%0d]: hit=%b st=%b want 0/(10 after LT)", i, hit16, rs16);
        end
      end
      if (i == 8) begin
        n_cmp++;
        if (hit16 !== 1'b1 || rt16 !== 2'b01 || gt16 !== 16'd7 || lt16 !== 16'd1) begin
          n_bad++;
          $display("FAIL break_hit: hit=%b type=%b gt=%0d lt=%0d want 1/01/7/1",
                   hit16, rt16, gt16, lt16);
        end
      end
    end
  endtask

  task automatic test_gap();
    stim = '{SRst, SEq, SEq, SIdle, SIdle, SIdle, SIdle, SIdle, SEq, SEq};
    foreach (stim[i]) begin
      step(stim[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL gap[%0d]: got %h want %h", i, obs, e);
      end
      if (i >= 3 && i <= 7) begin
        n_cmp++;
        if (eq16 !== 16'd2 || hit16 !== 1'b0 || rs16 !== 2'b11) begin
          n_bad++;
          $display("FAIL gap_hold[%0d]: eq=%0d hit=%b st=%b want 2/0/11", i, eq16, hit16, rs16);
        end
      end
      if (i == 9) begin
        n_cmp++;
        if (hit16 !== 1'b1 || eq16 !== 16'd4) begin
          n_bad++;
          $display("FAIL gap_hit: hit=%b eq=%0d want 1/4", hit16, eq16);
        end
      end
    end
  endtask

  task automatic test_err();
    stim = '{SRst, SLt, SLt, SE000, SE110, SLt, SLt, SLt, SLt};
    foreach (stim[i]) begin
      step(stim[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL err[%0d]: got %h want %h", i, obs, e);
      end
      if (i == 4) begin
        n_cmp++;
        if (err16 !== 16'd2 || rs16 !== 2'b00 || lt16 !== 16'd2) begin
          n_bad++;
          $display("FAIL err_flags: err=%0d st=%b lt=%0d want 2/00/2", err16, rs16, lt16);
        end
      end
      if (i == 7 || i == 8) begin
        n_cmp++;
        if (hit16 !== (i == 8) || (i == 8 && rt16 !== 2'b10)) begin
          n_bad++;
          $display("FAIL err_restart[%0d]: hit=%b type=%b", i, hit16, rt16);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int hits4;
    int hits16;
    hits4 = 0;
    hits16 = 0;
    stim = '{SRst};
    repeat (20) stim.push_back(SGt);
    foreach (stim[i]) begin
      step(stim[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL sat[%0d]: got %h want %h", i, obs, e);
      end
      if (hit4 === 1'b1) hits4++;
      if (hit16 === 1'b1) hits16++;
    end
    n_cmp++;
    if (gt4 !== 4'd15 || gt16 !== 16'd20 || hits4 != 1 || hits16 != 1) begin
      n_bad++;
      $display("FAIL sat_final: gt4=%0d gt16=%0d hits4=%0d hits16=%0d want 15/20/1/1",
               gt4, gt16, hits4, hits16);
    end
  endtask

  task automatic test_clr();
    stim = '{SRst, SEq, SEq, SEq, SClrEq, SEq};
    foreach (stim[i]) begin
      step(stim[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL clr[%0d]: got %h want %h", i, obs, e);
      end
      if (i == 4) begin
        n_cmp++;
        if (obs !== 90'd0) begin
          n_bad++;
          $display("FAIL clr_zero: got %h want all zero", obs);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if (eq16 !== 16'd1 || hit16 !== 1'b0) begin
          n_bad++;
          $display("FAIL clr_after: eq=%0d hit=%b want 1/0", eq16, hit16);
        end
      end
    end
  endtask

  task automatic test_rst_midrun();
    stim = '{SRst, SEq, SEq, SEq, SRstEq, SEq, SEq, SEq, SEq};
    foreach (stim[i]) begin
      step(stim[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL rst_mid[%0d]: got %h want %h", i, obs, e);
      end
      if (i >= 4) begin
        n_cmp++;
        if (hit16 !== (i == 8)) begin
          n_bad++;
          $display("FAIL rst_mid_hit[%0d]: hit=%b want %b", i, hit16, (i == 8));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_eq_run();
    test_break();
    test_gap();
    test_err();
    test_saturation();
    test_clr();
    test_rst_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
